// File: rtl/compressed_line_unpacker_if.sv
// Bus bundle between the line unpacker, its word source and its codeword decoder.
// o_err is present only when UNPACK_LENGTH_CHECK_EN is defined.
interface compressed_line_unpacker_if;
  logic        i_line_start;
  logic [7:0]  i_line_length;
  logic        o_line_ready;
  logic        i_in_valid;
  logic [63:0] i_in_data;
  logic        o_in_ready;
  logic [63:0] o_window;
  logic        o_window_valid;
  logic [6:0]  o_avail;
  logic        i_consume;
  logic [6:0]  i_consume_length;
  logic        o_line_done;
`ifdef UNPACK_LENGTH_CHECK_EN
  logic        o_err;

  modport master (
    output i_line_start, i_line_length, i_in_valid, i_in_data, i_consume, i_consume_length,
    input  o_line_ready, o_in_ready, o_window, o_window_valid, o_avail, o_line_done, o_err
  );
  modport slave (
    input  i_line_start, i_line_length, i_in_valid, i_in_data, i_consume, i_consume_length,
    output o_line_ready, o_in_ready, o_window, o_window_valid, o_avail, o_line_done, o_err
  );
`else
  modport master (
    output i_line_start, i_line_length, i_in_valid, i_in_data, i_consume, i_consume_length,
    input  o_line_ready, o_in_ready, o_window, o_window_valid, o_avail, o_line_done
  );
  modport slave (
    input  i_line_start, i_line_length, i_in_valid, i_in_data, i_consume, i_consume_length,
    output o_line_ready, o_in_ready, o_window, o_window_valid, o_avail, o_line_done
  );
`endif
endinterface

// File: rtl/compressed_line_unpacker.sv
// Unpacks a 64-bit-padded compressed line into a left-aligned decode window.
// Optional sticky length/overrun checking via UNPACK_LENGTH_CHECK_EN (adds o_err).
module compressed_line_unpacker #(
  parameter int unsigned CACHE_LINE = 128,
  parameter int unsigned WORD_SIZE  = 64
) (
  input logic                       i_clk,
  input logic                       i_reset,
  compressed_line_unpacker_if.slave bus
);
  localparam logic [7:0] LINE_BITS = 8'(CACHE_LINE);
  localparam logic [7:0] WORD_BITS = 8'(WORD_SIZE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CACHE_LINE-1:0] buf_q, buf_d, shifted;
  logic [7:0]            level_q, level_d, rem_q, rem_d;
  logic [7:0]            lvl_after, rem_after, clamp_len, min_lr;
  logic [1:0]            words_q, words_d;
  logic [6:0]            cons_len, avail_d;
  logic                  do_cons, do_push;
  logic                  line_ready_q, in_ready_q, win_valid_q, line_done_q;
  logic [6:0]            avail_q;

  always_comb begin
    cons_len  = '0;
    do_cons   = (state_q == RUN) && bus.i_consume && win_valid_q;
    // Oversized requests saturate to what is available; zero stays a no-op.
    if (do_cons)
      cons_len = (bus.i_consume_length > avail_q) ? avail_q : bus.i_consume_length;
    do_push   = bus.i_in_valid && in_ready_q;
    shifted   = buf_q << cons_len;
    lvl_after = level_q - {1'b0, cons_len};
    rem_after = rem_q - {1'b0, cons_len};
    clamp_len = (bus.i_line_length > LINE_BITS) ? LINE_BITS : bus.i_line_length;

    state_d = state_q;
    buf_d   = buf_q;
    level_d = level_q;
    rem_d   = rem_q;
    words_d = words_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_line_start) begin
          rem_d   = clamp_len;
          words_d = 2'((clamp_len + WORD_BITS - 8'd1) / WORD_BITS);
          buf_d   = '0;
          level_d = '0;
          state_d = (clamp_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        buf_d   = shifted;
        level_d = lvl_after;
        rem_d   = rem_after;
        // New word lands directly behind the bits still held after this cycle's consume.
        if (do_push) begin
          buf_d   = shifted | ({bus.i_in_data, {WORD_SIZE{1'b0}}} >> lvl_after);
          level_d = lvl_after + WORD_BITS;
          words_d = words_q - 2'd1;
        end
        if (do_cons && (rem_after == '0)) begin
          buf_d   = '0;
          level_d = '0;
          words_d = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    min_lr  = (level_d < rem_d) ? level_d : rem_d;
    avail_d = (min_lr > WORD_BITS) ? WORD_BITS[6:0] : min_lr[6:0];
  end

`ifdef UNPACK_LENGTH_CHECK_EN
  logic err_q, err_set;
  always_comb begin
    err_set = (bus.i_consume && (!win_valid_q || (bus.i_consume_length == '0) ||
                                 (bus.i_consume_length > avail_q))) ||
              (bus.i_in_valid && (state_q != RUN));
  end
  assign bus.o_err = err_q;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      level_q      <= '0;
      rem_q        <= '0;
      words_q      <= '0;
      line_ready_q <= 1'b1;
      in_ready_q   <= 1'b0;
      win_valid_q  <= 1'b0;
      line_done_q  <= 1'b0;
      avail_q      <= '0;
`ifdef UNPACK_LENGTH_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      level_q      <= level_d;
      rem_q        <= rem_d;
      words_q      <= words_d;
      line_ready_q <= (state_d == IDLE);
      line_done_q  <= (state_d == DONE);
      in_ready_q   <= (state_d == RUN) && (level_d <= WORD_BITS) && (words_d != '0);
      win_valid_q  <= (state_d == RUN) &&
                      ((level_d >= WORD_BITS) || ((level_d >= rem_d) && (rem_d != '0)));
      avail_q      <= avail_d;
`ifdef UNPACK_LENGTH_CHECK_EN
      if (err_set) err_q <= 1'b1;
`endif
    end
  end

  assign bus.o_window       = buf_q[CACHE_LINE-1 -: WORD_SIZE];
  assign bus.o_line_ready   = line_ready_q;
  assign bus.o_in_ready     = in_ready_q;
  assign bus.o_window_valid = win_valid_q;
  assign bus.o_avail        = avail_q;
  assign bus.o_line_done    = line_done_q;
endmodule

// File: tb/tb_compressed_line_unpacker.sv
// Self-checking bench for compressed_line_unpacker against a bit-stream reference model.
// Checks o_err as well when UNPACK_LENGTH_CHECK_EN is defined.
module tb_compressed_line_unpacker;
  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  compressed_line_unpacker_if bus();

  compressed_line_unpacker #(.CACHE_LINE(128), .WORD_SIZE(64)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a line is a bit stream; track words delivered and bits consumed.
  typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
  mstate_t     m_state;
  int          m_len, m_pushed, m_consumed;
  logic [63:0] m_words [2];
  bit          m_err;

  function automatic int m_level();
    return (m_state == M_RUN) ? m_pushed * 64 - m_consumed : 0;
  endfunction
  function automatic int m_rem();
    return (m_state == M_RUN) ? m_len - m_consumed : 0;
  endfunction
  function automatic int m_avail();
    int a;
    a = m_level();
    if (m_rem() < a) a = m_rem();
    if (a > 64) a = 64;
    return a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_len = 0; m_pushed = 0; m_consumed = 0; m_err = 1'b0;
  endtask

  // Drive one cycle of inputs, check current outputs against the model, advance past the edge.
  task automatic cycle(input logic ls, input logic [7:0] ll, input logic iv,
                       input logic [63:0] id, input logic cv, input logic [6:0] cl);
    int lvl, rem, av, c, nwords;
    logic wv, inr;
    logic [63:0] mask;
    logic [127:0] s;
    bus.i_line_start = ls; bus.i_line_length = ll;
    bus.i_in_valid = iv;   bus.i_in_data = id;
    bus.i_consume = cv;    bus.i_consume_length = cl;
    lvl = m_level(); rem = m_rem(); av = m_avail();
    nwords = (m_len + 63) / 64;
    wv  = (m_state == M_RUN) && ((lvl >= 64) || ((lvl >= rem) && (rem != 0)));
    inr = (m_state == M_RUN) && (lvl <= 64) && (m_pushed < nwords);
    chk("line_ready",   64'(bus.o_line_ready),   64'(m_state == M_IDLE));
    chk("line_done",    64'(bus.o_line_done),    64'(m_state == M_DONE));
    chk("in_ready",     64'(bus.o_in_ready),     64'(inr));
    chk("window_valid", 64'(bus.o_window_valid), 64'(wv));
    chk("avail",        64'(bus.o_avail),        64'(av));
    mask = (av == 0) ? 64'h0 : (~64'h0 << (64 - av));
    s = {m_words[0], m_words[1]} << m_consumed;
    chk("window", bus.o_window & mask, s[127:64] & mask);
`ifdef UNPACK_LENGTH_CHECK_EN
    chk("err", 64'(bus.o_err), 64'(m_err));
    if ((cv && (!wv || cl == 0 || int'(cl) > av)) || (iv && m_state != M_RUN)) m_err = 1'b1;
`endif
    c = 0;
    if (m_state == M_RUN && cv && wv) c = (int'(cl) > av) ? av : int'(cl);
    case (m_state)
      M_IDLE: if (ls) begin
        m_len = (ll > 8'd128) ? 128 : int'(ll);
        m_pushed = 0; m_consumed = 0;
        m_state = (m_len == 0) ? M_DONE : M_RUN;
      end
      M_RUN: begin
        if (iv && inr) begin m_words[m_pushed] = id; m_pushed++; end
        m_consumed += c;
        if (c > 0 && m_consumed == m_len) m_state = M_DONE;
      end
      default: m_state = M_IDLE;
    endcase
    @(posedge i_clk); #1;
  endtask

  task automatic idle();
    cycle(1'b0, 8'd0, 1'b0, 64'h0, 1'b0, 7'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int len, av, cl;
    bus.i_line_start = 1'b0; bus.i_line_length = '0; bus.i_in_valid = 1'b0;
    bus.i_in_data = '0; bus.i_consume = 1'b0; bus.i_consume_length = '0;
    i_reset = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_window", bus.o_window, 64'h0);
    chk("reset_ready", 64'(bus.o_line_ready), 64'(1));
    i_reset = 1'b1;
    idle();

    // Reset mid-line after one word
    cycle(1'b1, 8'd128, 1'b0, 64'h0, 1'b0, 7'd0);
    cycle(1'b0, 8'd0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 7'd0);
    bus.i_in_valid = 1'b0;
    #2 i_reset = 1'b0;
    #1;
    chk("midreset_avail", 64'(bus.o_avail), 64'(0));
    chk("midreset_ready", 64'(bus.o_line_ready), 64'(1));
    chk("midreset_wvalid", 64'(bus.o_window_valid), 64'(0));
    @(posedge i_clk); #1;
    chk("midreset_done", 64'(bus.o_line_done), 64'(0));
    i_reset = 1'b1;
    model_reset();
    idle();

    // 128-bit line, two words, consume 64 + 64
    cycle(1'b1, 8'd128, 1'b0, 64'h0, 1'b0, 7'd0);
    cycle(1'b0, 8'd0, 1'b1, {32{2'b10}}, 1'b0, 7'd0);
    chk("full_win_a", bus.o_window, {32{2'b10}});
    cycle(1'b0, 8'd0, 1'b1, {32{2'b01}}, 1'b0, 7'd0);
    chk("full_in_ready_low", 64'(bus.o_in_ready), 64'(0));
    cycle(1'b0, 8'd0, 1'b0, 64'h0, 1'b1, 7'd64);
    chk("full_win_5", bus.o_window, {32{2'b01}});
    cycle(1'b0, 8'd0, 1'b0, 64'h0, 1'b1, 7'd64);
    chk("full_done_pulse", 64'(bus.o_line_done), 64'(1));
    idle();
    idle();

    // 70-bit line, consume 4, 60, 6 (then again with an oversized final consume)
    for (int pass = 0; pass < 2; pass++) begin
      cycle(1'b1, 8'd70, 1'b0, 64'h0, 1'b0, 7'd0);
      cycle(1'b0, 8'd0, 1'b1, 64'hF000_0000_0000_0000, 1'b0, 7'd0);
      cycle(1'b0, 8'd0, 1'b1, 64'hFC00_0000_0000_0000, 1'b0, 7'd0);
      cycle(1'b0, 8'd0, 1'b0, 64'h0, 1'b1, 7'd4);
      chk("l70_win_after4", bus.o_window, 64'h0000_0000_0000_000F);
      cycle(1'b0, 8'd0, 1'b0, 64'h0, 1'b1, 7'd60);
      chk("l70_avail6", 64'(bus.o_avail), 64'(6));
      chk("l70_win_fc", bus.o_window & 64'hFC00_0000_0000_0000, 64'hFC00_0000_0000_0000);
      cycle(1'b0, 8'd0, 1'b0, 64'h0, 1'b1, (pass == 0) ? 7'd6 : 7'd8);
      chk("l70_done", 64'(bus.o_line_done), 64'(1));
`ifdef UNPACK_LENGTH_CHECK_EN
      chk("l70_err", 64'(bus.o_err), 64'(pass));
`endif
      idle();
    end

    // Zero-length line
    cycle(1'b1, 8'd0, 1'b0, 64'h0, 1'b0, 7'd0);
    chk("zero_done", 64'(bus.o_line_done), 64'(1));
    chk("zero_in_ready", 64'(bus.o_in_ready), 64'(0));
    idle();

    // Push and consume in the same cycle
    cycle(1'b1, 8'd200, 1'b0, 64'h0, 1'b0, 7'd0);
    cycle(1'b0, 8'd0, 1'b1, 64'h0, 1'b0, 7'd0);
    cycle(1'b0, 8'd0, 1'b1, '1, 1'b1, 7'd10);
    chk("simul_window", bus.o_window, 64'h0000_0000_0000_03FF);
    chk("simul_avail", 64'(bus.o_avail), 64'(64));
    cycle(1'b0, 8'd0, 1'b0, 64'h0, 1'b1, 7'd64);
    chk("simul_avail_tail", 64'(bus.o_avail), 64'(54));
    cycle(1'b0, 8'd0, 1'b0, 64'h0, 1'b1, 7'd54);
    idle();

    // Randomized lines
    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(0, 200);
      cycle(1'b1, 8'(len), 1'b0, 64'h0, 1'b0, 7'd0);
      for (int k = 0; k < 400 && m_state != M_IDLE; k++) begin
        av = m_avail();
        cl = ($urandom_range(0, 3) != 0) ? $urandom_range(1, (av > 0) ? av : 1)
                                         : $urandom_range(0, 127);
        cycle(1'($urandom_range(0, 1)), 8'($urandom), 
              (m_state == M_RUN) && ($urandom_range(0, 3) != 0),
              {$urandom, $urandom}, ($urandom_range(0, 9) < 7), 7'(cl));
      end
      chk("line_finished", 64'(m_state == M_IDLE), 64'(1));
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/compressed_line_unpacker.md
Name: compressed_line_unpacker

Overview:
- Decompression-side counterpart of the compressor's length accumulator and packing path.
- Accepts the packed, 64-bit-padded compressed stream one word at a time.
- Presents a left-aligned 64-bit window of unconsumed bits to the downstream codeword decoder, which returns the length of each decoded codeword.
- Tracks per-line bit budget (≤128 bits), discards line-end padding and signals line completion.

Parameters:
- CACHE_LINE, 128, maximum compressed bits per line; also the internal buffer depth.
- WORD_SIZE, 64, input word width and window width.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  async active-low reset.
- i_line_start  in  1  start a new line; accepted only when o_line_ready=1.
- i_line_length  in  8  compressed bit length of the line; 0 and >128 are handled as described under Behaviour.
- o_line_ready  out  1  high in IDLE.
- i_in_valid  in  1  input word valid.
- i_in_data  in  64  packed word; bit 63 is the first stream bit.
- o_in_ready  out  1  input handshake ready.
- o_window  out  64  next unconsumed bits; o_window[63] is the next bit. Bits beyond o_avail are don't-care.
- o_window_valid  out  1  window holds the full next codeword candidate.
- o_avail  out  7  min(level, remaining, 64).
- i_consume  in  1  decoder consumed bits this cycle.
- i_consume_length  in  7  1..64 bits consumed.
- o_line_done  out  1  one-cycle pulse at line end.
- o_err  out  1  sticky error; present only with the macro.

Behaviour:
- Reset (async, i_reset=0):
  - state=IDLE, buffer=0, level=0, remaining=0, words_left=0.
  - Outputs: o_line_ready=1, o_in_ready=0, o_window_valid=0, o_avail=0, o_line_done=0, o_window=0, o_err=0.
  - Reset mid-line drops all buffered bits; no o_line_done.
- State IDLE:
  - On i_line_start: remaining = min(i_line_length, 128); words_left = ceil(remaining/64) (0..2); go to RUN.
  - If the length is 0, go straight to DONE.
- State RUN:
  - o_in_ready = (level ≤ 64) && (words_left ≠ 0).
  - Push on i_in_valid && o_in_ready: word inserted at buffer bits [127−L : 64−L], where L = level − consumed_this_cycle. Then level += 64, words_left −= 1.
  - Consume on i_consume && o_window_valid: buffer shifts left by i_consume_length; level and remaining both drop by i_consume_length.
  - Push and consume in the same cycle are both applied.
  - o_window_valid = (level ≥ 64) || (level ≥ remaining && remaining ≠ 0).
  - o_window = buffer[127:64], registered with no extra latency. Window updates the cycle after a push or consume.
  - When remaining reaches 0 after a consume, go to DONE. In the same update, force level=0 and buffer=0; the residual bits are line padding.
  - i_line_start is ignored in RUN.
- State DONE: o_line_done=1 for exactly one cycle, then IDLE. o_line_ready is 0 in DONE.
- Illegal consume: i_consume with i_consume_length > o_avail or =0. Without the macro, the length is saturated to o_avail and 0 is a no-op.
- Widths:
  - level and remaining are 8 bits, range 0..128.
  - Subtraction never wraps because of the saturation above.
- Throughput: one push and one consume per cycle sustained. The first window is valid 1 cycle after the first accepted word.

Optional Feature:
- Macro: UNPACK_LENGTH_CHECK_EN.
- Defined:
  - o_err is present.
  - o_err is set and held until reset on any of the following:
    - a consume with length 0;
    - a consume with length > o_avail;
    - a consume while o_window_valid=0;
    - i_in_valid held in DONE or IDLE for more than 0 cycles with words_left=0 (overrun).
  - Saturation still applies.
- Undefined: the o_err port and its logic are removed; saturation only.

Test Plan:
- Reset mid-RUN after one 64-bit word pushed -> next cycle level=0, o_line_ready=1, o_window_valid=0, no o_line_done.
- Line length 128, words 0xAAAA…AAAA then 0x5555…5555, consume 64 and 64 -> windows 0xAAAA…AAAA then 0x5555…5555; o_in_ready drops after 2 words; o_line_done pulses one cycle after the second consume.
- Line length 70, words 0xF000_0000_0000_0000 and 0xFC00_0000_0000_0000, consume 4,60,6 -> windows start 0xF…, 0x0…, 0xFC…; o_avail before the last consume =6; the 58 padding bits are discarded.
- Line length 0 -> o_line_done pulse the cycle after i_line_start, no input words accepted.
- Simultaneous push and consume: level=64, consume 10 with a push in the same cycle -> level 118, new word starts at window bit 9 (buffer bit 73).
- With UNPACK_LENGTH_CHECK_EN: o_avail=6, consume 8 -> o_err=1 sticky, remaining drops by 6, line completes.
